// File: rtl/bounce_generator.sv
// bounce_generator
//   Emulates a mechanical switch: every transition of a clean synchronous
//   level is replayed on bounce_out as a burst of pseudo-random glitches
//   for BOUNCE_CYCLES clocks, after which the output settles on the new
//   level. With enable low the block is a one-cycle pass-through.
//
// Ports
//   clock         in   single clock domain
//   reset         in   synchronous, active-high
//   enable        in   1 = bounce emulation, 0 = pass-through
//   clean_in      in   clean requested level (already synchronous to clock)
//   bounce_out    out  emulated bouncy switch signal, registered
//   busy          out  high while a bounce window is active
//   toggle_count  out  bounce_out edges in the current/last burst, saturating
module bounce_generator #(
  parameter int          BOUNCE_CYCLES    = 120_000,
  parameter int          MIN_PULSE_CYCLES = 60,
  parameter int          PULSE_RANGE_BITS = 10,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1,
  parameter logic        INIT_LEVEL       = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       clean_in,
  output logic       bounce_out,
  output logic       busy,
  output logic [7:0] toggle_count
);

  localparam int WIN_W = $clog2(BOUNCE_CYCLES);
  localparam int PUL_W = $clog2(MIN_PULSE_CYCLES + 2**PULSE_RANGE_BITS);

  // An all-zero Galois LFSR would lock up, so a zero seed is remapped.
  localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BOUNCE_CYCLES - 1);
  localparam logic [PUL_W-1:0] PUL_BASE = PUL_W'(MIN_PULSE_CYCLES - 1);

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t           state, state_next;
  logic [15:0]      lfsr, lfsr_adv;
  logic [PUL_W-1:0] pulse, pulse_load;
  logic [WIN_W-1:0] window;
  logic             target;
  logic [7:0]       count_inc;
  logic             reversal, win_done;

  // 16-bit Galois LFSR, right shift, taps 16'hB400.
  assign lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Pulse width is drawn from the LFSR value before it advances; the counter
  // is loaded with width-1 so it expires after exactly width cycles.
  assign pulse_load = PUL_BASE + PUL_W'(lfsr[PULSE_RANGE_BITS-1:0]);

  assign count_inc = (toggle_count == 8'hFF) ? 8'hFF : toggle_count + 8'd1;
  assign reversal  = (clean_in != target);
  assign win_done  = (window == '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (reversal) state_next = BOUNCE;
        // A reversal restarts the window, so it always keeps us in BOUNCE.
        BOUNCE:  if (!reversal && win_done) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == BOUNCE);
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      bounce_out   <= INIT_LEVEL;
      target       <= INIT_LEVEL;
      lfsr         <= SEED;
      window       <= '0;
      pulse        <= '0;
      toggle_count <= 8'd0;
    end else if (!enable) begin
      // Pass-through: counters, LFSR and toggle_count are frozen.
      bounce_out <= clean_in;
      target     <= clean_in;
    end else if (state == IDLE) begin
      if (reversal) begin
        target       <= clean_in;
        bounce_out   <= clean_in;
        window       <= WIN_LOAD;
        pulse        <= pulse_load;
        lfsr         <= lfsr_adv;
        toggle_count <= 8'd1;
      end
    end else if (!reversal && win_done) begin
      // Window expired: settle on the target level.
      bounce_out <= target;
      if (bounce_out != target) toggle_count <= count_inc;
    end else begin
      if (reversal) begin
        target <= clean_in;
        window <= WIN_LOAD;
      end else begin
        window <= window - 1'b1;
      end
      // The glitch train runs on undisturbed across a reversal.
      if (pulse == '0) begin
        bounce_out   <= ~bounce_out;
        pulse        <= pulse_load;
        lfsr         <= lfsr_adv;
        toggle_count <= count_inc;
      end else begin
        pulse <= pulse - 1'b1;
      end
    end
  end

endmodule

// File: doc/bounce_generator.md
# bounce_generator

Synthesizable switch-bounce emulator that is the transmit-side counterpart of the `debounce` filter. It takes a clean, synchronous level and replays every transition on `bounce_out` as a burst of pseudo-random glitches, then settles on the new level. It sits in front of `debounce` / `bounce_detector` in on-board self-test builds and in benches, replacing `!key_8` as `async_in`. This lets filter settings be characterized without a mechanical key.

## Interface
- `BOUNCE_CYCLES`, default 120_000: length of the bounce window in clock cycles (10 ms at 12 MHz). Must be ≥ 2.
- `MIN_PULSE_CYCLES`, default 60: minimum glitch pulse width in cycles. Must be ≥ 1.
- `PULSE_RANGE_BITS`, default 10: random extension width. Each pulse lasts `MIN_PULSE_CYCLES + lfsr[PULSE_RANGE_BITS-1:0]` cycles. Range is 1..16.
- `LFSR_SEED`, default 16'hACE1: reset value of the LFSR. A value of 0 is replaced by 16'h0001.
- `INIT_LEVEL`, default 1'b0: reset level of `bounce_out` and of the target.

Ports:
- `clock`  in  1: single clock domain.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: 1 selects bounce emulation; 0 selects pass-through.
- `clean_in`  in  1: clean requested level. Synchronous to `clock`; the driver is responsible for this.
- `bounce_out`  out  1: emulated bouncy switch signal, registered.
- `busy`  out  1: high while a bounce window is active.
- `toggle_count`  out  8: number of `bounce_out` edges in the current or last burst. Saturates at 255.

## Operation
- State: `IDLE`/`BOUNCE`, `target`, window counter, pulse counter, LFSR, and output register.
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400. It advances only when a new pulse width is drawn. The width uses the LFSR value before the advance.
- `enable`=0, any state:
  - Next cycle: `bounce_out`←`clean_in`, `target`←`clean_in`, state←`IDLE`.
  - Counters and `toggle_count` hold their values. The LFSR holds.
- `IDLE`, `enable`=1, `clean_in`≠`target` (start):
  - `target`←`clean_in`; `bounce_out`←`clean_in` (first edge).
  - window←`BOUNCE_CYCLES-1`; pulse←drawn width−1; LFSR advances; `toggle_count`←1.
  - State←`BOUNCE`.
- `BOUNCE`, evaluated in priority order each cycle:
  1. `clean_in`≠`target` (reversal): `target`←`clean_in`; window←`BOUNCE_CYCLES-1`. Pulse logic proceeds as in rule 3.
  2. Else if window==0: `bounce_out`←`target`, state←`IDLE`. Apply `toggle_count`+1 only if this changes `bounce_out`.
  3. Else: window decrements.
     - If pulse==0: `bounce_out`←~`bounce_out`; pulse←new width−1; LFSR advances; `toggle_count`+1.
     - Otherwise pulse decrements.
- `busy` = (state==`BOUNCE`), registered.
- Counter widths: window counter is `$clog2(BOUNCE_CYCLES)` bits. Pulse counter is `$clog2(MIN_PULSE_CYCLES + 2**PULSE_RANGE_BITS)` bits. No wrap is permitted.
- Reset (overrides everything): state `IDLE`; `bounce_out`=`target`=`INIT_LEVEL`; LFSR=seed; `busy`=0; `toggle_count`=0; counters 0.

## Timing
- Start detected at cycle N:
  - `bounce_out`=new level and `busy`=1 at N+1.
  - `busy` stays high for exactly `BOUNCE_CYCLES` cycles (N+1..N+`BOUNCE_CYCLES`).
  - `bounce_out`=`target` and `busy`=0 from N+`BOUNCE_CYCLES`+1.
- Every high or low interval inside a burst lasts between `MIN_PULSE_CYCLES` and `MIN_PULSE_CYCLES+2^PULSE_RANGE_BITS−1` cycles. The final interval may be truncated by window expiry.
- Reversal at cycle R: `busy` falls at R+`BOUNCE_CYCLES`+1, and the final level is the reversed value.
- Pass-through latency is 1 cycle.
- Output is deterministic: identical stimulus after reset produces an identical waveform.

## Test plan
- Reset: drive `reset` for 2 cycles with `INIT_LEVEL`=0 → `bounce_out`=0, `busy`=0, `toggle_count`=0. No edges while `clean_in`=0.
- Pass-through: `enable`=0, `clean_in` 0→1 at cycle 10, 1→0 at cycle 13 → `bounce_out` rises at 11, falls at 14, `busy` never asserts.
- Single burst: `BOUNCE_CYCLES`=1000, `MIN_PULSE_CYCLES`=10, `PULSE_RANGE_BITS`=4; `clean_in` 0→1 at N. Required:
  - `bounce_out`=1 at N+1.
  - `busy` high for exactly 1000 cycles.
  - Every interior interval is 10..25 cycles.
  - Level is 1 from N+1001.
  - `toggle_count` equals the edge count seen by the monitor.
  - Intervals match a reference LFSR model seeded 16'hACE1.
- Reversal: as above, `clean_in` 1→0 at N+500 → `busy` low at N+1501, final `bounce_out`=0, `toggle_count` correct.
- Mid-burst abort:
  - Assert `reset` at N+300 → next cycle all outputs at reset values; the next burst replays the seed sequence.
  - `enable`=0 at N+300 → `bounce_out`=`clean_in` at N+301, `busy`=0.
- Loopback: drive `debounce` (`FILTER_HZ`=10000, `FILTER_COUNTER_MAX`=3) from `bounce_out` with 20 random presses → the debounce output shows exactly 20 rising edges.
